// File: rtl/ifid_skid_buf_if.sv
// ifid_skid_buf_if: fetch-side and decode-side handshake bundle for the IF/ID skid buffer.
//   fetch_inst/fetch_pc/fetch_valid : word offered by fetch
//   fetch_hold                      : stall back to fetch (re-present same PC)
//   flush                           : redirect, kill buffered work
//   id_ready/id_valid/id_inst/id_pc : head entry handshake towards decode
//   occupancy                       : entries currently stored
// Modports: slave = the buffer, master = the surrounding pipeline.
interface ifid_skid_buf_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] fetch_inst;
  logic [WIDTH-1:0] fetch_pc;
  logic             fetch_valid;
  logic             fetch_hold;
  logic             flush;
  logic             id_ready;
  logic             id_valid;
  logic [WIDTH-1:0] id_inst;
  logic [WIDTH-1:0] id_pc;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output fetch_inst, fetch_pc, fetch_valid, flush, id_ready,
    input  fetch_hold, id_valid, id_inst, id_pc, occupancy
  );

  modport slave (
    input  fetch_inst, fetch_pc, fetch_valid, flush, id_ready,
    output fetch_hold, id_valid, id_inst, id_pc, occupancy
  );
endinterface

// File: rtl/ifid_skid_buf.sv
// ifid_skid_buf: IF/ID boundary skid buffer. Captures {pc, inst} pairs from fetch into
// an in-order circular buffer, presents the oldest to decode, holds fetch when full,
// and drops all buffered work on flush.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : ifid_skid_buf_if.slave (fetch handshake, flush, decode handshake, occupancy)
// Optional (macro IFID_PERF_CNT_EN):
//   hold_cycles  : saturating count of cycles with fetch_hold = 1
//   flush_events : saturating count of cycles with flush = 1
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module ifid_skid_buf #(
  parameter int unsigned      DEPTH    = 2,
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] NOP_INST = '0
) (
  input  logic              clk,
  input  logic              rst,
  ifid_skid_buf_if.slave    bus
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [31:0]       hold_cycles,
  output logic [31:0]       flush_events
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] inst;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic valid_c;
  logic hold_c;
  logic push_c;
  logic pop_c;

  // Handshake decode; a pop frees a slot in the same cycle, so a full buffer
  // only holds fetch when decode is not taking the head.
  always_comb begin
    valid_c = (count != '0);
    hold_c  = (count == CNT_W'(DEPTH)) & ~bus.id_ready;
    pop_c   = valid_c & bus.id_ready;
    push_c  = bus.fetch_valid & ~hold_c & ~bus.flush;
  end

  // Pointer/count state; flush drops everything, including a head popped this cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care out of reset so no reset term.
  always_ff @(posedge clk) begin
    if (rst && push_c) begin
      mem[wr_ptr] <= '{pc: bus.fetch_pc, inst: bus.fetch_inst};
    end
  end

  // Decode-facing outputs are a pure function of state; no fetch-to-decode bypass.
  always_comb begin
    bus.id_valid   = valid_c;
    bus.id_inst    = valid_c ? mem[rd_ptr].inst : NOP_INST;
    bus.id_pc      = valid_c ? mem[rd_ptr].pc   : '0;
    bus.occupancy  = count;
    bus.fetch_hold = hold_c;
  end

`ifdef IFID_PERF_CNT_EN
  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_cycles  <= '0;
      flush_events <= '0;
    end else begin
      if (hold_c && (hold_cycles != '1))        hold_cycles  <= hold_cycles + 32'd1;
      if (bus.flush && (flush_events != '1))    flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: doc/ifid_skid_buf.md
Name: ifid_skid_buf

Overview:
- IF/ID boundary stage between the fetch stage and decode; replaces the plain IF/ID register.
- Captures instruction/PC pairs produced by fetch into a small in-order skid buffer.
- Presents the oldest pair to decode with a valid/ready handshake, back-pressures fetch through a hold signal, and discards all buffered work on a redirect (jump/branch flush).

Parameters:
- DEPTH, 2, number of buffered {pc, inst} entries; power of two, >= 2.
- WIDTH, 32, instruction and PC width (`COMMON_WIDTH` range).
- NOP_INST, 32'h0000_0000, value driven on id_inst while id_valid = 0.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low; sampled on rising clk edge.
- fetch_inst  input  WIDTH  instruction word from fetch (ROM output).
- fetch_pc  input  WIDTH  PC of fetch_inst.
- fetch_valid  input  1  fetch word valid this cycle; tie high if fetch is always valid.
- fetch_hold  output  1  to fetch stall input; fetch must re-present the same PC next cycle.
- flush  input  1  redirect from jump/branch resolution; kill all buffered entries.
- id_ready  input  1  decode accepts the head entry this cycle.
- id_valid  output  1  head entry valid.
- id_inst  output  WIDTH  head instruction, or NOP_INST when invalid.
- id_pc  output  WIDTH  head PC, or 0 when invalid.
- occupancy  output  $clog2(DEPTH+1)  entries currently stored.

Behaviour:
- Storage: circular buffer of DEPTH entries, with write pointer, read pointer and count registers. Pointers wrap modulo DEPTH.
- Reset (rst = 0 at an edge):
  - count, wr_ptr and rd_ptr are set to 0.
  - id_valid = 0, id_inst = NOP_INST, id_pc = 0, occupancy = 0, fetch_hold = 0.
  - Entry contents are don't-care.
- pop = id_valid & id_ready.
- fetch_hold = (count == DEPTH) & ~id_ready. This is combinational; a pop in the same cycle frees a slot, so a full buffer with id_ready = 1 does not hold.
- push = fetch_valid & ~fetch_hold & ~flush.
- Latency: a word pushed at edge N appears on id_* after edge N (visible in cycle N+1). There is no combinational fetch-to-decode bypass.
- id_valid = (count != 0). id_inst and id_pc are the head entry when valid, otherwise NOP_INST and 0.
- Count update:
  - push & ~pop: +1.
  - pop & ~push: -1.
  - push & pop: unchanged, with both pointers advancing.
  - Count never exceeds DEPTH and never underflows.
- Full boundary: with count == DEPTH and id_ready = 0, push = 0 and fetch is held. The word is not lost because fetch re-presents it.
- Empty boundary: with count == 0, pop is impossible (id_valid = 0). id_ready is ignored.
- Flush:
  - At the next edge, count, wr_ptr and rd_ptr are set to 0.
  - The fetch word in the flush cycle is never written.
  - A head popped in the same cycle as flush counts as consumed (it is the redirecting instruction).
  - id_valid = 0 in the cycle after the flush. The first post-redirect fetch word can be pushed in that cycle.
- Priority: rst > flush > push/pop.
- Reset mid-operation: all buffered entries are dropped and no output glitches to a stale valid.
- Entry ordering is strictly FIFO: PCs leave in the order accepted.

Optional Feature:
- Macro: IFID_PERF_CNT_EN.
- Defined:
  - Adds output ports hold_cycles [31:0] and flush_events [31:0].
  - hold_cycles increments on each cycle with fetch_hold = 1.
  - flush_events increments on each cycle with flush = 1.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0 on rst.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then fetch_valid = 1 with PCs 0x0, 0x4, 0x8 and id_ready = 1 every cycle -> id_pc sequence 0x0, 0x4, 0x8 starting one cycle after each push; occupancy stays at 1; fetch_hold never asserts.
- id_ready = 0 while pushing PCs 0x10 and 0x14 -> occupancy = 2 and fetch_hold = 1 with fetch presenting 0x18; raising id_ready drains 0x10, 0x14, 0x18 in order with no duplicate or drop.
- Full buffer (0x20, 0x24), id_ready = 1 and fetch presenting 0x28 in the same cycle -> fetch_hold = 0, 0x20 popped, 0x28 pushed, occupancy stays 2.
- Buffer holds 0x30, 0x34; assert flush together with fetch PC 0x38 and id_ready = 1 -> next cycle id_valid = 0, occupancy = 0, and 0x34/0x38 never appear; a subsequent push of 0x100 appears one cycle later.
- Assert rst = 0 mid-stream with occupancy = 2 -> next cycle id_valid = 0, id_inst = NOP_INST, id_pc = 0, occupancy = 0; rst = 1 with rst high on clk edge resumes normal capture.
- With IFID_PERF_CNT_EN defined: 3 held cycles and 2 flushes -> hold_cycles = 3, flush_events = 2; a counter preloaded at 32'hFFFF_FFFF stays at saturation.
